can_reg_access_responder: RTL

//  Target side of the controller's register-access handshakes. Serves the write path
//  (Controller2DEMUX_CS/addr_bus -> DEMUX2Controller_ack) and the read path
//  (Controller2MUX_CS/addr_bus1 -> MUX2Controller_ack).

---
 rtl/can_reg_access_responder_pkg.sv | 43 ++++
 rtl/can_ack_fsm.sv | 47 ++++
 rtl/can_reg_access_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/can_reg_access_responder_pkg.sv
// Shared definitions for the CAN register-access responder: the register
// address map seen by the controller and the ack handshake state encoding.
package can_reg_access_responder_pkg;

  // Writable configuration registers
  localparam logic [7:0] ADDR_SRR   = 8'h00;
  localparam logic [7:0] ADDR_MSR   = 8'h04;
  localparam logic [7:0] ADDR_BRPR  = 8'h08;
  localparam logic [7:0] ADDR_BTR   = 8'h0C;

  // Read-only status words
  localparam logic [7:0] ADDR_ECR   = 8'h10;
  localparam logic [7:0] ADDR_ESR   = 8'h14;
  localparam logic [7:0] ADDR_SR    = 8'h18;

  // Writable TX staging registers; a write to TXDW2 launches the frame
  localparam logic [7:0] ADDR_TXID  = 8'h30;
  localparam logic [7:0] ADDR_TXDLC = 8'h34;
  localparam logic [7:0] ADDR_TXDW1 = 8'h38;
  localparam logic [7:0] ADDR_TXDW2 = 8'h3C;

  // Read-only RX FIFO head words
  localparam logic [7:0] ADDR_RXID  = 8'h50;
  localparam logic [7:0] ADDR_RXDLC = 8'h54;
  localparam logic [7:0] ADDR_RXDW1 = 8'h58;
  localparam logic [7:0] ADDR_RXDW2 = 8'h5C;

  // Acceptance filter enable and first filter word; filter k sits at AF0 + 4*k
  localparam logic [7:0] ADDR_AFR   = 8'h60;
  localparam logic [7:0] ADDR_AF0   = 8'h64;

  // Four-phase acknowledge handshake states
  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_e;

  // True when addr selects acceptance-filter word k
  function automatic logic af_match(input logic [7:0] addr, input int k);
    return addr == (ADDR_AF0 + 8'(4 * k));
  endfunction

endpackage

// File: rtl/can_ack_fsm.sv
// Two-state four-phase acknowledge handshake. A request seen in IDLE is
// captured for exactly one edge; ack then stays high until the request drops,
// so the next capture cannot happen before ack has been withdrawn.
module can_ack_fsm
  import can_reg_access_responder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  output logic capture,
  output logic ack
);

  ack_state_e state_q, state_d;

  // State register; reset drops ack immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and single-edge capture strobe
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ACK_IDLE: begin
        if (cs) begin
          capture = 1'b1;
          state_d = ACK_BUSY;
        end
      end
      ACK_BUSY: begin
        if (!cs) begin
          state_d = ACK_IDLE;
        end
      end
      default: state_d = ACK_IDLE;
    endcase
  end

  assign ack = (state_q == ACK_BUSY);

endmodule

// File: rtl/can_reg_access_responder.sv
// Target side of the controller register-access handshakes. Holds the
// writable config, TX staging and acceptance-filter registers, and returns
// status/RX words or register contents on the registered read bus.
module can_reg_access_responder
  import can_reg_access_responder_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AF_REGS = 8
) (
  input  logic                    sys_clk,
  input  logic                    IP2Can_reset_n,
  input  logic                    Controller2DEMUX_CS,
  input  logic [7:0]              addr_bus,
  input  logic [DW-1:0]           IP2Can_data,
  output logic                    DEMUX2Controller_ack,
  input  logic                    Controller2MUX_CS,
  input  logic [7:0]              addr_bus1,
  output logic                    MUX2Controller_ack,
  output logic [DW-1:0]           Can2IP_data,
  input  logic [DW-1:0]           ecr_i,
  input  logic [DW-1:0]           esr_i,
  input  logic [DW-1:0]           sr_i,
  input  logic [DW-1:0]           rx_id_i,
  input  logic [DW-1:0]           rx_dlc_i,
  input  logic [DW-1:0]           rx_dw1_i,
  input  logic [DW-1:0]           rx_dw2_i,
  output logic [DW-1:0]           srr_q,
  output logic [DW-1:0]           msr_q,
  output logic [DW-1:0]           brpr_q,
  output logic [DW-1:0]           btr_q,
  output logic [DW-1:0]           tx_id_q,
  output logic [DW-1:0]           tx_dlc_q,
  output logic [DW-1:0]           tx_dw1_q,
  output logic [DW-1:0]           tx_dw2_q,
  output logic [DW-1:0]           afr_q,
  output logic [AF_REGS*DW-1:0]   af_bank_q,
  output logic                    tx_load,
  output logic                    soft_rst,
  output logic                    addr_err
);

  logic          w_cap, r_cap;
  logic          w_hit, r_hit;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] srr_d, msr_d, brpr_d, btr_d;
  logic [DW-1:0] tx_id_d, tx_dlc_d, tx_dw1_d, tx_dw2_d, afr_d;
  logic [DW-1:0] af_q [AF_REGS];
  logic [DW-1:0] af_d [AF_REGS];
  logic [DW-1:0] can2ip_data_q, can2ip_data_d;
  logic          tx_load_q, tx_load_d;
  logic          soft_rst_q, soft_rst_d;
  logic          addr_err_q, addr_err_d;

  can_ack_fsm u_wr_ack (
    .clk     (sys_clk),
    .rst_n   (IP2Can_reset_n),
    .cs      (Controller2DEMUX_CS),
    .capture (w_cap),
    .ack     (DEMUX2Controller_ack)
  );

  can_ack_fsm u_rd_ack (
    .clk     (sys_clk),
    .rst_n   (IP2Can_reset_n),
    .cs      (Controller2MUX_CS),
    .capture (r_cap),
    .ack     (MUX2Controller_ack)
  );

  // Write decode: update the addressed register on the capture edge only
  always_comb begin
    srr_d      = srr_q;
    msr_d      = msr_q;
    brpr_d     = brpr_q;
    btr_d      = btr_q;
    tx_id_d    = tx_id_q;
    tx_dlc_d   = tx_dlc_q;
    tx_dw1_d   = tx_dw1_q;
    tx_dw2_d   = tx_dw2_q;
    afr_d      = afr_q;
    af_d       = af_q;
    tx_load_d  = 1'b0;
    soft_rst_d = 1'b0;
    w_hit      = 1'b0;
    if (w_cap) begin
      case (addr_bus)
        ADDR_SRR: begin
          // Reset request bit is a strobe; it never stays set
          w_hit      = 1'b1;
          srr_d      = {IP2Can_data[DW-1:1], 1'b0};
          soft_rst_d = IP2Can_data[0];
        end
        ADDR_MSR:   begin w_hit = 1'b1; msr_d    = IP2Can_data; end
        ADDR_BRPR:  begin w_hit = 1'b1; brpr_d   = IP2Can_data; end
        ADDR_BTR:   begin w_hit = 1'b1; btr_d    = IP2Can_data; end
        ADDR_TXID:  begin w_hit = 1'b1; tx_id_d  = IP2Can_data; end
        ADDR_TXDLC: begin w_hit = 1'b1; tx_dlc_d = IP2Can_data; end
        ADDR_TXDW1: begin w_hit = 1'b1; tx_dw1_d = IP2Can_data; end
        ADDR_TXDW2: begin
          w_hit     = 1'b1;
          tx_dw2_d  = IP2Can_data;
          tx_load_d = 1'b1;
        end
        ADDR_AFR:   begin w_hit = 1'b1; afr_d    = IP2Can_data; end
        default: ;
      endcase
      for (int k = 0; k < AF_REGS; k++) begin
        if (af_match(addr_bus, k)) begin
          w_hit   = 1'b1;
          af_d[k] = IP2Can_data;
        end
      end
    end
  end

  // Read mux from current register state, so a same-edge write is not visible
  always_comb begin
    rd_word = '0;
    r_hit   = 1'b1;
    case (addr_bus1)
      ADDR_SRR:   rd_word = srr_q;
      ADDR_MSR:   rd_word = msr_q;
      ADDR_BRPR:  rd_word = brpr_q;
      ADDR_BTR:   rd_word = btr_q;
      ADDR_ECR:   rd_word = ecr_i;
      ADDR_ESR:   rd_word = esr_i;
      ADDR_SR:    rd_word = sr_i;
      ADDR_TXID:  rd_word = tx_id_q;
      ADDR_TXDLC: rd_word = tx_dlc_q;
      ADDR_TXDW1: rd_word = tx_dw1_q;
      ADDR_TXDW2: rd_word = tx_dw2_q;
      ADDR_RXID:  rd_word = rx_id_i;
      ADDR_RXDLC: rd_word = rx_dlc_i;
      ADDR_RXDW1: rd_word = rx_dw1_i;
      ADDR_RXDW2: rd_word = rx_dw2_i;
      ADDR_AFR:   rd_word = afr_q;
      default:    r_hit   = 1'b0;
    endcase
    for (int k = 0; k < AF_REGS; k++) begin
      if (af_match(addr_bus1, k)) begin
        r_hit   = 1'b1;
        rd_word = af_q[k];
      end
    end
    can2ip_data_d = r_cap ? rd_word : can2ip_data_q;
    // One error pulse even when both paths miss on the same edge
    addr_err_d    = (w_cap & ~w_hit) | (r_cap & ~r_hit);
  end

  // Register file, read data and event pulses
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n) begin
    if (!IP2Can_reset_n) begin
      srr_q         <= '0;
      msr_q         <= '0;
      brpr_q        <= '0;
      btr_q         <= '0;
      tx_id_q       <= '0;
      tx_dlc_q      <= '0;
      tx_dw1_q      <= '0;
      tx_dw2_q      <= '0;
      afr_q         <= '0;
      for (int k = 0; k < AF_REGS; k++) af_q[k] <= '0;
      can2ip_data_q <= '0;
      tx_load_q     <= 1'b0;
      soft_rst_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      srr_q         <= srr_d;
      msr_q         <= msr_d;
      brpr_q        <= brpr_d;
      btr_q         <= btr_d;
      tx_id_q       <= tx_id_d;
      tx_dlc_q      <= tx_dlc_d;
      tx_dw1_q      <= tx_dw1_d;
      tx_dw2_q      <= tx_dw2_d;
      afr_q         <= afr_d;
      af_q          <= af_d;
      can2ip_data_q <= can2ip_data_d;
      tx_load_q     <= tx_load_d;
      soft_rst_q    <= soft_rst_d;
      addr_err_q    <= addr_err_d;
    end
  end

  for (genvar g = 0; g < AF_REGS; g++) begin : g_af_bank
    assign af_bank_q[g*DW +: DW] = af_q[g];
  end

  assign Can2IP_data = can2ip_data_q;
  assign tx_load     = tx_load_q;
  assign soft_rst    = soft_rst_q;
  assign addr_err    = addr_err_q;

endmodule
